// File: rtl/seg_scan_driver_if.sv
// Display-side bundle of the seven-segment scan driver: scan clock and digit
// data in, active-low anode/segment/decimal-point drive and scan status out.
interface seg_scan_driver_if #(
    parameter int DIGITS = 4,
    parameter int IDXW   = 2
);
    logic                  scanClk;
    logic [4*DIGITS-1:0]   digits;
    logic [DIGITS-1:0]     blank;
    logic [DIGITS-1:0]     dp;
    logic [DIGITS-1:0]     an;
    logic [6:0]            seg;
    logic                  dpOut;
    logic [IDXW-1:0]       scanIdx;
    logic                  scanTick;

    modport master (
        output scanClk, digits, blank, dp,
        input  an, seg, dpOut, scanIdx, scanTick
    );

    modport slave (
        input  scanClk, digits, blank, dp,
        output an, seg, dpOut, scanIdx, scanTick
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver: the divided scan clock is synchronised,
// edge-detected into a tick that steps the digit index, and outputs are registered.
module seg_scan_driver #(
    parameter int DIGITS = 4,
    parameter int IDXW   = 2
) (
    input  logic               clk,
    input  logic               reset,
    seg_scan_driver_if.slave   bus
);

    logic                s1_q, s2_q, s3_q;
    logic                tick;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [3:0]          nib;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // scanClk is asynchronous: two flops to settle it, a third to find its rising edge
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= bus.scanClk;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign tick = s2_q & ~s3_q;

    always_comb begin
        idx_d = idx_q;
        if (tick) begin
            if (idx_q == IDXW'(DIGITS - 1))
                idx_d = '0;
            else
                idx_d = idx_q + IDXW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            idx_q <= '0;
        else
            idx_q <= idx_d;
    end

    assign nib = bus.digits[{idx_q, 2'b00} +: 4];

    always_comb begin
        an_d  = '1;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (!bus.blank[idx_q]) begin
            an_d[idx_q] = 1'b0;
            seg_d       = hex_to_seg(nib);
            dp_d        = ~bus.dp[idx_q];
        end
    end

    // Outputs refresh every cycle so data changes show without waiting for a tick
    always_ff @(posedge clk) begin
        if (reset) begin
            an_q  <= '1;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign bus.an       = an_q;
    assign bus.seg      = seg_q;
    assign bus.dpOut    = dp_q;
    assign bus.scanIdx  = idx_q;
    assign bus.scanTick = tick;

endmodule
